// File: rtl/c3lib_ckdiv_pkg.sv
// Shared types, constants and helpers for the programmable clock divider/inverter.
package c3lib_ckdiv_pkg;

  localparam int CKDIV_DIV_W_DFLT = 4;

  // Config record at the default divide width.
  typedef struct packed {
    logic [CKDIV_DIV_W_DFLT-1:0] div;
    logic                        inv;
  } ckdiv_cfg_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ckdiv_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/c3lib_ckdiv_ch.sv
// One divider channel: half-period counter, phase, staged config applied at period boundaries.
// With C3LIB_CKDIV_EDGE_PULSE_EN defined, edge_pls_o flags the cycle before each clk_out_o rise.
module c3lib_ckdiv_ch
  import c3lib_ckdiv_pkg::*;
#(
  parameter int DIV_W   = CKDIV_DIV_W_DFLT,
  parameter int RST_DIV = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             acc_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_inv_i,
  output logic             pend_o,
  output logic             upd_done_o,
  output logic             clk_out_o
`ifdef C3LIB_CKDIV_EDGE_PULSE_EN
  ,
  output logic             edge_pls_o
`endif
);

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             inv;
  } ch_cfg_t;

  localparam logic [DIV_W-1:0] RST_DIV_L = RST_DIV[DIV_W-1:0];

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  ch_cfg_t          cur_q, cur_d;
  ch_cfg_t          pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             clk_out_q, clk_out_d;
  logic             upd_done_q, upd_done_d;
  logic             at_wrap;
  logic             at_bnd;
  logic             apply;

  always_comb begin
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    cur_d        = cur_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    upd_done_d   = 1'b0;
    at_wrap      = (cnt_q == cur_q.div);
    at_bnd       = at_wrap && phase_q;
    // A stopped channel has no period to protect, so staged config lands at once.
    apply        = pend_valid_q && (at_bnd || !en_i);

    if (!en_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (at_wrap) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    if (apply) begin
      cur_d        = pend_q;
      pend_valid_d = 1'b0;
      upd_done_d   = 1'b1;
    end else if (acc_i && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_d       = '{div: cfg_div_i, inv: cfg_inv_i};
    end

    clk_out_d = phase_d ^ cur_d.inv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      cur_q        <= '{div: RST_DIV_L, inv: 1'b0};
      pend_q       <= '{div: '0, inv: 1'b0};
      pend_valid_q <= 1'b0;
      clk_out_q    <= 1'b0;
      upd_done_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      cur_q        <= cur_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      clk_out_q    <= clk_out_d;
      upd_done_q   <= upd_done_d;
    end
  end

  assign pend_o     = pend_valid_q;
  assign upd_done_o = upd_done_q;
  assign clk_out_o  = clk_out_q;

`ifdef C3LIB_CKDIV_EDGE_PULSE_EN
  // Look-ahead on the flop input; held low while reset is asserted.
  assign edge_pls_o = ~rst & clk_out_d & ~clk_out_q;
`endif

endmodule

// File: rtl/c3lib_ckdiv_inv_prog.sv
// Multi-channel programmable clock divider/inverter with a staged valid/ready config port.
// Optional C3LIB_CKDIV_EDGE_PULSE_EN adds edge_pls, a strobe one cycle ahead of each clk_out rise.
module c3lib_ckdiv_inv_prog
  import c3lib_ckdiv_pkg::*;
#(
  parameter int  NUM_CH  = 4,
  parameter int  DIV_W   = CKDIV_DIV_W_DFLT,
  parameter int  RST_DIV = 0,
  localparam int CH_W    = c3lib_ckdiv_pkg::ckdiv_sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_inv,
  output logic [NUM_CH-1:0] upd_done,
  output logic [NUM_CH-1:0] clk_out
`ifdef C3LIB_CKDIV_EDGE_PULSE_EN
  ,
  output logic [NUM_CH-1:0] edge_pls
`endif
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] acc;

  // Out-of-range channel numbers decode to no channel and always see ready.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) begin
        cfg_ready = ~pend[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign sel[gi] = (int'(cfg_ch) == gi);
      assign acc[gi] = cfg_valid & sel[gi] & ~pend[gi];

      c3lib_ckdiv_ch #(
        .DIV_W   (DIV_W),
        .RST_DIV (RST_DIV)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .en_i       (ch_en[gi]),
        .acc_i      (acc[gi]),
        .cfg_div_i  (cfg_div),
        .cfg_inv_i  (cfg_inv),
        .pend_o     (pend[gi]),
        .upd_done_o (upd_done[gi]),
        .clk_out_o  (clk_out[gi])
`ifdef C3LIB_CKDIV_EDGE_PULSE_EN
        ,
        .edge_pls_o (edge_pls[gi])
`endif
      );
    end
  endgenerate

endmodule

// File: tb/tb_c3lib_ckdiv_inv_prog.sv
// Self-checking bench: directed scenarios plus randomized traffic against a period-position model.
module tb_c3lib_ckdiv_inv_prog;
  localparam int NUM_CH = 5;
  localparam int DIV_W  = 4;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_inv;
  logic [NUM_CH-1:0] upd_done;
  logic [NUM_CH-1:0] clk_out;
`ifdef C3LIB_CKDIV_EDGE_PULSE_EN
  logic [NUM_CH-1:0] edge_pls;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Model: position inside the current period, active ratio/polarity, one staged entry.
  int m_pos[NUM_CH], m_div[NUM_CH], m_pdiv[NUM_CH];
  bit m_inv[NUM_CH], m_pend[NUM_CH], m_pinv[NUM_CH], m_upd[NUM_CH], m_clk[NUM_CH];

  logic d_seq[$], u_seq[$];
  bit   r_seq[$];
  int   runs[$];

  c3lib_ckdiv_inv_prog #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_DIV(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_inv   (cfg_inv),
    .upd_done  (upd_done),
    .clk_out   (clk_out)
`ifdef C3LIB_CKDIV_EDGE_PULSE_EN
    ,
    .edge_pls  (edge_pls)
`endif
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pos[i] = 0; m_div[i] = 0; m_inv[i] = 0; m_pend[i] = 0;
      m_pdiv[i] = 0; m_pinv[i] = 0; m_upd[i] = 0; m_clk[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit old_pend[NUM_CH];
    int c;
    c = int'(cfg_ch);
    for (int i = 0; i < NUM_CH; i++) old_pend[i] = m_pend[i];
    for (int i = 0; i < NUM_CH; i++) begin
      bit take;
      bit last;
      m_upd[i] = 0;
      if (ch_en[i]) begin
        last     = (m_pos[i] == 2 * (m_div[i] + 1) - 1);
        m_pos[i] = last ? 0 : m_pos[i] + 1;
        take     = last && m_pend[i];
      end else begin
        m_pos[i] = 0;
        take     = m_pend[i];
      end
      if (take) begin
        m_div[i] = m_pdiv[i]; m_inv[i] = m_pinv[i]; m_pend[i] = 0; m_upd[i] = 1;
      end
      m_clk[i] = (m_pos[i] > m_div[i]) ^ m_inv[i];
    end
    if (cfg_valid && c < NUM_CH && !old_pend[c]) begin
      m_pend[c] = 1; m_pdiv[c] = int'(cfg_div); m_pinv[c] = cfg_inv;
    end
  endfunction

  function automatic bit exp_ready();
    int c;
    c = int'(cfg_ch);
    return (c >= NUM_CH) ? 1'b1 : !m_pend[c];
  endfunction

  function automatic logic [NUM_CH-1:0] m_clk_vec();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_clk[i];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] m_upd_vec();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_upd[i];
    return v;
  endfunction

  // Full run lengths of d_seq, dropping the leading and trailing partial runs.
  function automatic void get_runs();
    int len;
    bit seen_edge;
    runs.delete(); len = 0; seen_edge = 0;
    for (int i = 1; i < d_seq.size(); i++) begin
      len++;
      if (d_seq[i] !== d_seq[i-1]) begin
        if (seen_edge) runs.push_back(len);
        seen_edge = 1; len = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cfg_drive(input int ch, input int dv, input bit iv);
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_div = DIV_W'(dv); cfg_inv = iv;
    #1;
    $display("cfg ch=%0d div=%0d inv=%0b ready=%0b", ch, dv, iv, cfg_ready);
  endtask

  task automatic run_cycles(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      d_seq.push_back(clk_out[ch]); r_seq.push_back(m_clk[ch]); u_seq.push_back(upd_done[ch]);
    end
  endtask

  task automatic clear_seq();
    d_seq.delete(); r_seq.delete(); u_seq.delete();
  endtask

  task automatic wait_upd(input int ch, input int lim, output bit seen);
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      tick();
      if (upd_done[ch] === 1'b1) seen = 1;
    end
  endtask

  task automatic test_reset();
    logic prev;
    ch_en = '1; cfg_valid = 0; cfg_ch = '0; cfg_div = '0; cfg_inv = 0;
    #1 rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++; if (clk_out !== '0) begin miscompares++; $display("FAIL rst_clk_out: got %b want %b", clk_out, {NUM_CH{1'b0}}); end
    vectors++; if (upd_done !== '0) begin miscompares++; $display("FAIL rst_upd_done: got %b want %b", upd_done, {NUM_CH{1'b0}}); end
    for (int c = 0; c < 8; c++) begin
      cfg_ch = CH_W'(c); #1;
      vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready ch%0d: got %b want 1", c, cfg_ready); end
    end
    cfg_ch = '0;
    @(negedge clk); rst = 1'b0;
    prev = clk_out[0];
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++; if (clk_out[0] === prev) begin miscompares++; $display("FAIL rst_toggle[%0d]: got %b want %b", i, clk_out[0], ~prev); end
      vectors++; if (clk_out !== m_clk_vec()) begin miscompares++; $display("FAIL rst_model[%0d]: got %b want %b", i, clk_out, m_clk_vec()); end
      prev = clk_out[0];
    end
  endtask

  task automatic test_ratio();
    bit seen;
    ch_en = '1; cfg_ch = 3'd1; #1;
    vectors++; if (cfg_ready !== exp_ready()) begin miscompares++; $display("FAIL ratio_ready: got %b want %b", cfg_ready, exp_ready()); end
    cfg_drive(1, 2, 0); tick(); cfg_valid = 0;
    wait_upd(1, 16, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL ratio_upd: got timeout want upd_done[1]"); end
    clear_seq(); run_cycles(1, 40); get_runs();
    vectors++; if (runs.size() < 6) begin miscompares++; $display("FAIL ratio_runs: got %0d runs want >=6", runs.size()); end
    foreach (runs[i]) begin
      vectors++; if (runs[i] != 3) begin miscompares++; $display("FAIL ratio_half[%0d]: got %0d want 3", i, runs[i]); end
    end
    foreach (d_seq[i]) begin
      vectors++; if (d_seq[i] !== r_seq[i]) begin miscompares++; $display("FAIL ratio_model[%0d]: got %b want %b", i, d_seq[i], r_seq[i]); end
    end
  endtask

  task automatic test_glitch_free();
    bit seen;
    int hs, wi, hb, he;
    ch_en = '1;
    cfg_drive(2, 3, 0); tick(); cfg_valid = 0;
    wait_upd(2, 32, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL glitch_upd0: got timeout want upd_done[2]"); end
    clear_seq(); hs = 0;
    for (int i = 0; i < 40 && hs < 2; i++) begin
      run_cycles(2, 1);
      hs = (d_seq[$] === 1'b1) ? hs + 1 : 0;
    end
    vectors++; if (hs < 2) begin miscompares++; $display("FAIL glitch_wait_high: got %0d want 2", hs); end
    wi = d_seq.size();
    cfg_drive(2, 1, 0); run_cycles(2, 1); cfg_valid = 0;
    run_cycles(2, 20);
    hb = wi - 1;
    while (hb > 0 && d_seq[hb-1] === 1'b1) hb--;
    he = wi;
    while (he < d_seq.size() - 1 && d_seq[he] === 1'b1) he++;
    vectors++; if (he - hb != 4) begin miscompares++; $display("FAIL glitch_old_high: got %0d want 4", he - hb); end
    vectors++; if (u_seq[he] !== 1'b1) begin miscompares++; $display("FAIL glitch_upd_at_bnd: got %b want 1", u_seq[he]); end
    get_runs();
    foreach (runs[i]) begin
      vectors++; if (runs[i] < 2) begin miscompares++; $display("FAIL glitch_runt[%0d]: got %0d want >=2", i, runs[i]); end
    end
    for (int i = runs.size() - 4; i < runs.size(); i++) begin
      vectors++; if (runs[i] != 2) begin miscompares++; $display("FAIL glitch_new_half[%0d]: got %0d want 2", i, runs[i]); end
    end
    foreach (d_seq[i]) begin
      vectors++; if (d_seq[i] !== r_seq[i]) begin miscompares++; $display("FAIL glitch_model[%0d]: got %b want %b", i, d_seq[i], r_seq[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit seen, got;
    ch_en = '1;
    cfg_drive(3, 7, 0); tick(); cfg_valid = 0;
    wait_upd(3, 16, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL bp_upd0: got timeout want upd_done[3]"); end
    cfg_drive(3, 5, 1);
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL bp_first_ready: got %b want 1", cfg_ready); end
    tick();
    cfg_drive(3, 2, 0);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      vectors++; if (cfg_ready !== exp_ready()) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b want %b", i, cfg_ready, exp_ready()); end
      if (cfg_ready === 1'b1) begin
        vectors++; if (upd_done[3] !== 1'b1) begin miscompares++; $display("FAIL bp_release: got upd_done %b want 1", upd_done[3]); end
        got = 1;
      end
      tick();
    end
    cfg_valid = 0;
    vectors++; if (!got) begin miscompares++; $display("FAIL bp_timeout: got held want accept"); end
    wait_upd(3, 32, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL bp_upd2: got timeout want upd_done[3]"); end
    clear_seq(); run_cycles(3, 24); get_runs();
    foreach (runs[i]) begin
      vectors++; if (runs[i] != 3) begin miscompares++; $display("FAIL bp_half[%0d]: got %0d want 3", i, runs[i]); end
    end
    foreach (d_seq[i]) begin
      vectors++; if (d_seq[i] !== r_seq[i]) begin miscompares++; $display("FAIL bp_model[%0d]: got %b want %b", i, d_seq[i], r_seq[i]); end
    end
  endtask

  task automatic test_disable();
    ch_en = '1; ch_en[0] = 1'b0;
    cfg_drive(0, 0, 1); tick(); cfg_valid = 0;
    vectors++; if (clk_out[0] !== 1'b0) begin miscompares++; $display("FAIL dis_static: got %b want 0", clk_out[0]); end
    vectors++; if (upd_done[0] !== 1'b0) begin miscompares++; $display("FAIL dis_upd_early: got %b want 0", upd_done[0]); end
    tick();
    vectors++; if (clk_out[0] !== 1'b1) begin miscompares++; $display("FAIL dis_inv_level: got %b want 1", clk_out[0]); end
    vectors++; if (upd_done[0] !== 1'b1) begin miscompares++; $display("FAIL dis_upd: got %b want 1", upd_done[0]); end
    ch_en[0] = 1'b1;
    tick();
    vectors++; if (clk_out[0] !== 1'b0) begin miscompares++; $display("FAIL reen_first: got %b want 0", clk_out[0]); end
    tick();
    vectors++; if (clk_out[0] !== 1'b1) begin miscompares++; $display("FAIL reen_second: got %b want 1", clk_out[0]); end
    vectors++; if (clk_out !== m_clk_vec()) begin miscompares++; $display("FAIL dis_model: got %b want %b", clk_out, m_clk_vec()); end
  endtask

  task automatic test_max_ratio();
    bit seen;
    ch_en = '1;
    cfg_drive(4, 15, 0); tick(); cfg_valid = 0;
    wait_upd(4, 16, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL max_upd: got timeout want upd_done[4]"); end
    clear_seq(); run_cycles(4, 100); get_runs();
    vectors++; if (runs.size() < 4) begin miscompares++; $display("FAIL max_runs: got %0d want >=4", runs.size()); end
    foreach (runs[i]) begin
      vectors++; if (runs[i] != 16) begin miscompares++; $display("FAIL max_half[%0d]: got %0d want 16", i, runs[i]); end
    end
  endtask

  task automatic test_bad_ch();
    ch_en = '1;
    for (int c = NUM_CH; c < 8; c++) begin
      cfg_drive(c, 9, 1);
      vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL bad_ready ch%0d: got %b want 1", c, cfg_ready); end
      tick();
    end
    cfg_valid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      vectors++; if (upd_done !== '0) begin miscompares++; $display("FAIL bad_upd[%0d]: got %b want 0", i, upd_done); end
      vectors++; if (clk_out !== m_clk_vec()) begin miscompares++; $display("FAIL bad_model[%0d]: got %b want %b", i, clk_out, m_clk_vec()); end
    end
  endtask

`ifdef C3LIB_CKDIV_EDGE_PULSE_EN
  task automatic test_edge_pulse();
    bit seen, pm;
    logic ep;
    int n;
    ch_en = '1;
    cfg_drive(1, 1, 0); tick(); cfg_valid = 0;
    wait_upd(1, 16, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL edge_upd: got timeout want upd_done[1]"); end
    n = 0;
    for (int i = 0; i < 24; i++) begin
      ep = edge_pls[1]; pm = m_clk[1];
      tick();
      vectors++; if (ep !== (m_clk[1] & ~pm)) begin miscompares++; $display("FAIL edge_pls[%0d]: got %b want %b", i, ep, m_clk[1] & ~pm); end
      if (ep === 1'b1) n++;
    end
    vectors++; if (n != 6) begin miscompares++; $display("FAIL edge_count: got %0d want 6", n); end
  endtask
`endif

  task automatic test_random();
    int k;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        k = $urandom_range(0, NUM_CH - 1);
        ch_en[k] = ~ch_en[k];
      end
      if ($urandom_range(0, 3) == 0) begin
        cfg_drive($urandom_range(0, 7), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3),
                  1'($urandom_range(0, 1)));
      end else begin
        cfg_valid = 0; cfg_ch = CH_W'($urandom_range(0, 7)); #1;
      end
      vectors++; if (cfg_ready !== exp_ready()) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, cfg_ready, exp_ready()); end
      tick();
      vectors++; if (clk_out !== m_clk_vec()) begin miscompares++; $display("FAIL rnd_clk[%0d]: got %b want %b", i, clk_out, m_clk_vec()); end
      vectors++; if (upd_done !== m_upd_vec()) begin miscompares++; $display("FAIL rnd_upd[%0d]: got %b want %b", i, upd_done, m_upd_vec()); end
    end
    cfg_valid = 0;
  endtask

  task automatic test_reset_mid();
    ch_en = '1;
    cfg_drive(4, 15, 0); tick(); cfg_valid = 0;
    repeat (40) tick();
    cfg_drive(4, 0, 1); tick(); cfg_valid = 0;
    cfg_ch = CH_W'(4);
    #2 rst = 1'b1;
    #1;
    model_reset();
    vectors++; if (clk_out !== '0) begin miscompares++; $display("FAIL mid_rst_clk: got %b want 0", clk_out); end
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 1", cfg_ready); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      vectors++; if (upd_done !== '0) begin miscompares++; $display("FAIL mid_rst_upd[%0d]: got %b want 0", i, upd_done); end
      vectors++; if (clk_out !== m_clk_vec()) begin miscompares++; $display("FAIL mid_rst_model[%0d]: got %b want %b", i, clk_out, m_clk_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_ratio();
    test_glitch_free();
    test_back_to_back();
    test_disable();
    test_max_ratio();
    test_bad_ch();
`ifdef C3LIB_CKDIV_EDGE_PULSE_EN
    test_edge_pulse();
`endif
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

endmodule
